// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared constants for the raster timing generator.
//  - Per-mode timing for 640x480@60, 800x600@60 and 1280x720@60:
//    horizontal/vertical active, front porch, sync width, back porch
//    and sync polarity (1 = active high).
//  - cw_required(): minimum counter width that holds both H_TOTAL-1
//    and V_TOTAL-1.
package video_timing_pkg;

    // 640x480@60, 25.175 MHz, negative syncs
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_H_POL    = 0;
    localparam int VGA_V_POL    = 0;

    // 800x600@60, 40 MHz, positive syncs
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FRONT  = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BACK   = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FRONT  = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BACK   = 23;
    localparam int SVGA_H_POL    = 1;
    localparam int SVGA_V_POL    = 1;

    // 1280x720@60, 74.25 MHz, positive syncs
    localparam int HD_H_ACTIVE = 1280;
    localparam int HD_H_FRONT  = 110;
    localparam int HD_H_SYNC   = 40;
    localparam int HD_H_BACK   = 220;
    localparam int HD_V_ACTIVE = 720;
    localparam int HD_V_FRONT  = 5;
    localparam int HD_V_SYNC   = 5;
    localparam int HD_V_BACK   = 20;
    localparam int HD_H_POL    = 1;
    localparam int HD_V_POL    = 1;

    // Smallest width able to represent the largest counter value.
    function automatic int cw_required(input int h_total, input int v_total);
        int max_count;
        max_count = (h_total > v_total) ? h_total - 1 : v_total - 1;
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// video_delay_line
// Enable-gated shift register used to hold the display-side timing
// behind the fetch port.
//  clk_pixel  in   pixel clock
//  rst_n      in   asynchronous active-low clear, loads RST_VAL into every stage
//  en         in   shift enable; low holds all stages
//  d          in   WIDTH-bit input word
//  q          out  d delayed by DEPTH enabled cycles
module video_delay_line #(
    parameter int                 WIDTH   = 1,
    parameter int                 DEPTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk_pixel,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Every stage clears to the idle word so a reset mid-frame leaves no
    // stale sync or data-enable queued behind the counters.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Parametrised raster timing generator with a lookahead fetch port.
//  clk_pixel     in   pixel clock
//  rst_n         in   asynchronous active-low reset
//  en            in   advance enable; low freezes counters and pipeline
//  fetch_valid   out  lookahead active-region flag
//  fetch_x/y     out  lookahead coordinates (0 outside the active range)
//  hsync/vsync   out  display syncs, active level H_POL / V_POL
//  video_active  out  display data-enable
//  pixel_x/y     out  display coordinates, PREFETCH cycles behind fetch
//  line_start    out  pulse on the first active pixel of each line
//  frame_start   out  pulse on pixel (0,0)
//  frame_count   out  completed-frame count, wraps at 2^FCW
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CW       = 12,
    parameter int PREFETCH = 0,
    parameter int FCW      = 16
) (
    input  logic           clk_pixel,
    input  logic           rst_n,
    input  logic           en,
    output logic           fetch_valid,
    output logic [CW-1:0]  fetch_x,
    output logic [CW-1:0]  fetch_y,
    output logic           hsync,
    output logic           vsync,
    output logic           video_active,
    output logic [CW-1:0]  pixel_x,
    output logic [CW-1:0]  pixel_y,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Pipeline word layout: {hs, vs, de, ls, fs, x, y}
    localparam int PW     = 2 * CW + 5;
    localparam int FS_BIT = 2 * CW;
    localparam int LS_BIT = 2 * CW + 1;
    localparam int DE_BIT = 2 * CW + 2;
    localparam int VS_BIT = 2 * CW + 3;
    localparam int HS_BIT = 2 * CW + 4;

    localparam logic HS_IDLE = (H_POL == 0);
    localparam logic VS_IDLE = (V_POL == 0);
    localparam logic [PW-1:0] RST_PL = {HS_IDLE, VS_IDLE, {(PW - 2){1'b0}}};

    if (CW < cw_required(H_TOTAL, V_TOTAL)) begin : g_cw_check
        $error("video_timing_gen: CW=%0d too small for %0dx%0d totals", CW, H_TOTAL, V_TOTAL);
    end
    if (PREFETCH < 0 || PREFETCH > 16) begin : g_prefetch_check
        $error("video_timing_gen: PREFETCH=%0d outside 0..16", PREFETCH);
    end

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic [PW-1:0] cur_pl;
    logic [PW-1:0] s1_pl;
    logic [PW-1:0] disp_pl;
    logic          fs_next;

    // Raster position; v advances only on the h wrap so vsync edges land on h=0.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (en) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // Timing word for the current position. Coordinates zero per axis, and
    // the strobes ride along so they come out of the final register aligned.
    always_comb begin
        logic h_vis;
        logic v_vis;
        logic in_hs;
        logic in_vs;
        h_vis  = int'(h) < H_ACTIVE;
        v_vis  = int'(v) < V_ACTIVE;
        in_hs  = (int'(h) >= HS_START) && (int'(h) < HS_END);
        in_vs  = (int'(v) >= VS_START) && (int'(v) < VS_END);
        cur_pl = {in_hs ? ~HS_IDLE : HS_IDLE,
                  in_vs ? ~VS_IDLE : VS_IDLE,
                  h_vis && v_vis,
                  (h == '0) && v_vis,
                  (h == '0) && (v == '0),
                  h_vis ? h : '0,
                  v_vis ? v : '0};
    end

    // Fetch stage, also the head of the display path.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            s1_pl <= RST_PL;
        end else if (en) begin
            s1_pl <= cur_pl;
        end
    end

    assign fetch_valid = s1_pl[DE_BIT];
    assign fetch_x     = s1_pl[2*CW-1:CW];
    assign fetch_y     = s1_pl[CW-1:0];

    // With no lookahead the fetch register doubles as the display register.
    // Otherwise the delay line feeds a final register kept here so that the
    // word about to reach the display is visible for the frame counter.
    if (PREFETCH == 0) begin : g_no_delay
        assign disp_pl = s1_pl;
        assign fs_next = cur_pl[FS_BIT];
    end else begin : g_delay
        logic [PW-1:0] pre_pl;
        logic [PW-1:0] disp_r;

        if (PREFETCH == 1) begin : g_direct
            assign pre_pl = s1_pl;
        end else begin : g_line
            video_delay_line #(
                .WIDTH   (PW),
                .DEPTH   (PREFETCH - 1),
                .RST_VAL (RST_PL)
            ) u_delay (
                .clk_pixel (clk_pixel),
                .rst_n     (rst_n),
                .en        (en),
                .d         (s1_pl),
                .q         (pre_pl)
            );
        end

        // Final display register.
        always_ff @(posedge clk_pixel or negedge rst_n) begin
            if (!rst_n) begin
                disp_r <= RST_PL;
            end else if (en) begin
                disp_r <= pre_pl;
            end
        end

        assign disp_pl = disp_r;
        assign fs_next = pre_pl[FS_BIT];
    end

    assign hsync        = disp_pl[HS_BIT];
    assign vsync        = disp_pl[VS_BIT];
    assign video_active = disp_pl[DE_BIT];
    assign line_start   = disp_pl[LS_BIT];
    assign frame_start  = disp_pl[FS_BIT];
    assign pixel_x      = disp_pl[2*CW-1:CW];
    assign pixel_y      = disp_pl[CW-1:0];

    // Counts on the same edge that raises frame_start, so frame N shows N
    // during its own first pixel.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (en && fs_next) begin
            frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
// Two generators on a shrunken raster (15 x 9, 135 cycles per frame):
//  A: PREFETCH=0, negative syncs, 16-bit frame counter
//  B: PREFETCH=4, positive syncs, 2-bit frame counter
// The driver pushes the expected outputs for every clock into a queue;
// a monitor pops one entry per clock and compares both generators.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 5, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int CW = 4;
    localparam int PRE_B = 4;
    localparam int FCW_A = 16;
    localparam int FCW_B = 2;
    // Counter position h=11 (inside hsync), v=6 (inside vsync)
    localparam int RST_POS = 6 * HT + 11;

    typedef struct {
        logic          fv;
        logic [CW-1:0] fx;
        logic [CW-1:0] fy;
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic          ls;
        logic          fs;
        int            fc;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } pair_t;

    logic clk_pixel;
    logic rst_n;
    logic en;

    logic              fv_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic [CW-1:0]     fx_a, fy_a, px_a, py_a;
    logic [FCW_A-1:0]  fc_a;
    logic              fv_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [CW-1:0]     fx_b, fy_b, px_b, py_b;
    logic [FCW_B-1:0]  fc_b;

    pair_t exp_q[$];
    int    k;
    int    n_checks;
    int    n_fail;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(0), .V_POL(0), .CW(CW), .PREFETCH(0), .FCW(FCW_A)
    ) dut_a (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .en(en),
        .fetch_valid(fv_a), .fetch_x(fx_a), .fetch_y(fy_a),
        .hsync(hs_a), .vsync(vs_a), .video_active(de_a),
        .pixel_x(px_a), .pixel_y(py_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1), .V_POL(1), .CW(CW), .PREFETCH(PRE_B), .FCW(FCW_B)
    ) dut_b (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .en(en),
        .fetch_valid(fv_b), .fetch_x(fx_b), .fetch_y(fy_b),
        .hsync(hs_b), .vsync(vs_b), .video_active(de_b),
        .pixel_x(px_b), .pixel_y(py_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Expected outputs after k enabled edges since reset. Fetch shows raster
    // position k-1, display shows position k-1-pre; frame_count is the
    // number of frame starts the display has shown.
    function automatic exp_t model(input int kk, input int pre, input logic hpol,
                                   input logic vpol, input int fcw);
        exp_t e;
        int q, h, v, d;
        e = '{default: 0};
        e.hs = ~hpol;
        e.vs = ~vpol;
        if (kk >= 1) begin
            q = (kk - 1) % FT;
            h = q % HT;
            v = q / HT;
            e.fv = (h < HA) && (v < VA);
            e.fx = (h < HA) ? CW'(h) : '0;
            e.fy = (v < VA) ? CW'(v) : '0;
        end
        d = kk - 1 - pre;
        if (d >= 0) begin
            q = d % FT;
            h = q % HT;
            v = q / HT;
            e.hs = (h >= HA + HF && h < HA + HF + HS) ? hpol : ~hpol;
            e.vs = (v >= VA + VF && v < VA + VF + VS) ? vpol : ~vpol;
            e.de = (h < HA) && (v < VA);
            e.px = (h < HA) ? CW'(h) : '0;
            e.py = (v < VA) ? CW'(v) : '0;
            e.ls = (h == 0) && (v < VA);
            e.fs = (h == 0) && (v == 0);
            e.fc = (d / FT + 1) % (1 << fcw);
        end
        return e;
    endfunction

    function automatic exp_t sampleA();
        exp_t s;
        s = '{fv_a, fx_a, fy_a, hs_a, vs_a, de_a, px_a, py_a, ls_a, fs_a, int'(fc_a)};
        return s;
    endfunction

    function automatic exp_t sampleB();
        exp_t s;
        s = '{fv_b, fx_b, fy_b, hs_b, vs_b, de_b, px_b, py_b, ls_b, fs_b, int'(fc_b)};
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic checkSet(input string tag, input exp_t act, input exp_t req);
        checkOutput({tag, ".fetch_valid"}, 32'(act.fv), 32'(req.fv));
        checkOutput({tag, ".fetch_x"},     32'(act.fx), 32'(req.fx));
        checkOutput({tag, ".fetch_y"},     32'(act.fy), 32'(req.fy));
        checkOutput({tag, ".hsync"},       32'(act.hs), 32'(req.hs));
        checkOutput({tag, ".vsync"},       32'(act.vs), 32'(req.vs));
        checkOutput({tag, ".video_active"},32'(act.de), 32'(req.de));
        checkOutput({tag, ".pixel_x"},     32'(act.px), 32'(req.px));
        checkOutput({tag, ".pixel_y"},     32'(act.py), 32'(req.py));
        checkOutput({tag, ".line_start"},  32'(act.ls), 32'(req.ls));
        checkOutput({tag, ".frame_start"}, 32'(act.fs), 32'(req.fs));
        checkOutput({tag, ".frame_count"}, 32'(act.fc), 32'(req.fc));
    endtask

    // One clock of stimulus: inputs change on the falling edge and the
    // expectation for the following rising edge is queued.
    task automatic applyStimulus(input logic en_val, input logic rst_val);
        pair_t p;
        @(negedge clk_pixel);
        en    = en_val;
        rst_n = rst_val;
        if (!rst_val) k = 0;
        else if (en_val) k++;
        p.a = model(k, 0, 1'b0, 1'b0, FCW_A);
        p.b = model(k, PRE_B, 1'b1, 1'b1, FCW_B);
        exp_q.push_back(p);
    endtask

    // Monitor: one comparison set per rising edge, sampled 2 ns after it.
    initial begin
        pair_t p;
        forever begin
            @(posedge clk_pixel);
            #2;
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                checkSet("A", sampleA(), p.a);
                checkSet("B", sampleB(), p.b);
            end
        end
    end

    initial begin
        bit found;
        n_checks = 0;
        n_fail   = 0;
        k        = 0;
        en       = 1'b0;
        rst_n    = 1'b0;

        checkOutput("cw_required_800x525", 32'(cw_required(800, 525)), 32'd10);
        checkOutput("cw_required_1650x750",
                    32'(cw_required(HD_H_ACTIVE + HD_H_FRONT + HD_H_SYNC + HD_H_BACK,
                                    HD_V_ACTIVE + HD_V_FRONT + HD_V_SYNC + HD_V_BACK)), 32'd11);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

        // Continuous run past the 2-bit counter wrap
        for (int i = 0; i < 5 * FT + 20; i++) applyStimulus(1'b1, 1'b1);

        // Stall pattern 1,0,0,1
        for (int i = 0; i < 160; i++) begin
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b1, 1'b1);
        end

        // Random enable, mostly high
        for (int i = 0; i < 1500; i++) applyStimulus($urandom_range(0, 3) != 0, 1'b1);

        // Run until the counter sits in hsync and vsync, then pulse reset
        found = 1'b0;
        for (int i = 0; i < FT + 2; i++) begin
            if (k % FT == RST_POS) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b1, 1'b1);
        end
        checkOutput("reset_point_reached", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b0);
        #1;
        checkSet("A.async_reset", sampleA(), model(0, 0, 1'b0, 1'b0, FCW_A));
        checkSet("B.async_reset", sampleB(), model(0, PRE_B, 1'b1, 1'b1, FCW_B));
        applyStimulus(1'b1, 1'b0);

        for (int i = 0; i < 2 * FT; i++) applyStimulus(1'b1, 1'b1);

        @(posedge clk_pixel);
        #4;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480 generator.
- Every horizontal and vertical interval, sync polarity and coordinate width is a parameter.
- Adds a frame-enable stall, line/frame strobes and a frame counter.
- Adds a lookahead fetch port that runs PREFETCH cycles ahead of the display outputs, so framebuffer/pattern sources with pipeline latency line up with the TMDS encoder input.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = negative)
V_POL, 0, vsync active level (0 = negative)
CW, 12, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
PREFETCH, 0, display delay relative to fetch port, 0..16 cycles
FCW, 16, frame counter width

Ports:
clk_pixel  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  advance enable; low freezes counters and pipeline
fetch_valid  out  1  lookahead active-region flag
fetch_x  out  CW  lookahead x; 0 outside active region
fetch_y  out  CW  lookahead y; 0 outside active region
hsync  out  1  display hsync, polarity H_POL
vsync  out  1  display vsync, polarity V_POL
video_active  out  1  display data-enable
pixel_x  out  CW  display x; 0 when inactive
pixel_y  out  CW  display y; 0 when inactive
line_start  out  1  one-cycle pulse on first active pixel of each line (display side)
frame_start  out  1  one-cycle pulse on pixel (0,0) (display side)
frame_count  out  FCW  completed-frame count, wraps modulo 2^FCW

Behaviour:
- Derived constants: H_TOTAL = sum of the H intervals; V_TOTAL = sum of the V intervals.
- Reset (rst_n low, asynchronous):
  - h, v, frame_count = 0.
  - hsync = ~H_POL; vsync = ~V_POL.
  - All other outputs 0.
  - Delay pipeline cleared to the same inactive values.
- Counters:
  - On a clk_pixel edge with en=1, h increments; h wraps H_TOTAL-1 -> 0.
  - On the h wrap, v increments; v wraps V_TOTAL-1 -> 0.
  - With en=0, every register holds and pulses are held at their current value. The upstream clock gate is responsible for en being level-like.
- Fetch stage: registered from the pre-edge counter value (1-cycle latency).
  - fetch_valid = (h < H_ACTIVE) && (v < V_ACTIVE).
  - fetch_x = h when h < H_ACTIVE, else 0.
  - fetch_y = v when v < V_ACTIVE, else 0.
- Display stage: registered from the same counter value, then delayed by PREFETCH enabled cycles through a shift pipeline. Total latency from counter to display is 1+PREFETCH cycles.
  - hsync active when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync active when V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC.
  - vsync changes aligned to h=0, matching the counter-based generator.
- PREFETCH=0: display outputs equal the fetch-stage values of the same cycle; the pipeline is bypassed with no register.
- Strobes and counter:
  - line_start = video_active && pixel_x==0.
  - frame_start = line_start && pixel_y==0. Both are derived in the final display register, not combinationally.
  - frame_count increments on the cycle frame_start asserts, so the first frame after reset reads 1 during its first pixel. It wraps at 2^FCW-1 -> 0.
- en low mid-line or mid-sync: no output changes. Resuming continues exactly where it stopped, with no skipped or duplicated pixel.
- Reset mid-frame: immediate return to reset values; timing restarts at h=0, v=0.
- Elaboration error if CW is too small or PREFETCH > 16.

Decomposition:
- Package video_timing_pkg:
  - Per-mode parameter constants for 640x480@60, 800x600@60 and 1280x720@60 (intervals and polarities).
  - A function returning the required CW.
- One sub-module: video_delay_line. Parametrised WIDTH/DEPTH shift register with enable and async active-low clear, using a per-stage reset value. Carries {hsync, vsync, de, x, y}.

Test Plan:
- Defaults, PREFETCH=0, en=1:
  - hsync low exactly 96 cycles per line, starting 656 cycles after line start.
  - Period 800 cycles.
  - video_active high 640 cycles per line for 480 lines.
  - vsync low for 2 lines starting at line 490; frame = 420000 cycles.
- PREFETCH=4:
  - fetch_valid/x/y lead video_active/pixel_x/pixel_y by exactly 4 cycles across line and frame wrap (x 639 -> 0, y 479 -> 0).
- H_POL=1, V_POL=1, 1280x720 package constants:
  - hsync high 40 cycles; line 1650 cycles; vsync high 5 lines; 750 lines.
- en pattern 1,0,0,1 repeated:
  - Pixel sequence identical to the continuous run with stall cycles removed.
  - Outputs stable during stalls.
- Pulses and counter:
  - frame_start fires once per 420000 enabled cycles; line_start fires 480 times per frame.
  - frame_count=1 at first frame_start.
  - FCW=2: frame_count wraps 3 -> 0 on the 4th frame.
- Async reset pulse mid-sync (h=700, v=491):
  - Outputs take reset values immediately, without a clock edge.
  - After release, first fetch_valid=1 with fetch_x=0, fetch_y=0 on the first enabled edge.
